// File: rtl/rtc_calendar_alarm_if.sv
// Set/alarm/control bus and time outputs of the RTC calendar core.
// The board top level drives the master side, the core is the slave.
interface rtc_calendar_alarm_if #(
    parameter int N_ALARMS = 4
);
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic          set_en;
    logic [2:0]    set_sel;
    logic [6:0]    set_val;
    logic          al_wr;
    logic [AW-1:0] al_idx;
    logic [4:0]    al_hour;
    logic [5:0]    al_min;
    logic          al_en;
    logic          dismiss;
    logic          snooze;
    logic [5:0]    sec;
    logic [5:0]    min;
    logic [4:0]    hour;
    logic [4:0]    day;
    logic [3:0]    month;
    logic [6:0]    year;
    logic          sec_tick;
    logic          ring;
    logic [AW-1:0] ring_idx;
    logic          set_err;

    modport master (
        output set_en, set_sel, set_val,
        output al_wr, al_idx, al_hour, al_min, al_en,
        output dismiss, snooze,
        input  sec, min, hour, day, month, year,
        input  sec_tick, ring, ring_idx, set_err
    );

    modport slave (
        input  set_en, set_sel, set_val,
        input  al_wr, al_idx, al_hour, al_min, al_en,
        input  dismiss, snooze,
        output sec, min, hour, day, month, year,
        output sec_tick, ring, ring_idx, set_err
    );
endinterface

// File: rtl/rtc_calendar_alarm.sv
// Real-time clock/calendar with 1 Hz enable, alarm table, snooze
// and range-checked set interface, all in the CK50M domain.
module rtc_calendar_alarm #(
    parameter int TICK_DIV   = 50000000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 10,
    parameter int SNOOZE_MIN = 5
) (
    input logic              CK50M,
    input logic              RSTn,
    rtc_calendar_alarm_if.slave bus
);
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    function automatic logic [4:0] max_day(
        input logic [3:0] m,
        input logic [6:0] y
    );
        logic [4:0] d;
        case (m)
            4'd2:    d = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6,
            4'd9, 4'd11: d = 5'd30;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    logic [PW-1:0] presc;
    logic          tick_q, pending, set_err_q;
    logic [5:0]    sec_q, min_q;
    logic [4:0]    hour_q, day_q;
    logic [3:0]    month_q;
    logic [6:0]    year_q;
    logic [4:0]    ah_q [N_ALARMS];
    logic [5:0]    am_q [N_ALARMS];
    logic          ae_q [N_ALARMS];
    state_t        state;
    logic          ring_q;
    logic [AW-1:0] ridx_q;
    logic [5:0]    cnt;
    logic [4:0]    tgt_h;
    logic [5:0]    tgt_m;

    logic [5:0] n_sec, n_min;
    logic [4:0] n_hour, n_day, md_cur, md_set;
    logic [3:0] n_month;
    logic [6:0] n_year;
    logic       adv_req, adv, set_ok, sec_wr;
    logic       hit, match, snz_hit;
    logic [AW-1:0] hit_idx;
    logic [6:0] sm;
    logic [5:0] s_min;
    logic [4:0] s_hour;

    assign md_cur  = max_day(month_q, year_q);
    assign adv_req = tick_q | pending;
    assign adv     = adv_req & ~bus.set_en;

    always_comb begin
        n_sec   = sec_q + 6'd1;
        n_min   = min_q;
        n_hour  = hour_q;
        n_day   = day_q;
        n_month = month_q;
        n_year  = year_q;
        if (sec_q == 6'd59) begin
            n_sec = 6'd0;
            n_min = min_q + 6'd1;
            if (min_q == 6'd59) begin
                n_min  = 6'd0;
                n_hour = hour_q + 5'd1;
                if (hour_q == 5'd23) begin
                    n_hour = 5'd0;
                    n_day  = day_q + 5'd1;
                    if (day_q == md_cur) begin
                        n_day   = 5'd1;
                        n_month = month_q + 4'd1;
                        if (month_q == 4'd12) begin
                            n_month = 4'd1;
                            n_year  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                        end
                    end
                end
            end
        end
    end

    // Scan downwards so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ae_q[i] && ah_q[i] == n_hour && am_q[i] == n_min) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    assign match   = adv & hit & (n_sec == 6'd0);
    assign snz_hit = adv & (n_sec == 6'd0) &
                     (n_hour == tgt_h) & (n_min == tgt_m);

    always_comb begin
        md_set = (bus.set_sel == 3'd4) ?
                 max_day(bus.set_val[3:0], year_q) :
                 max_day(month_q, bus.set_val);
        case (bus.set_sel)
            3'd0, 3'd1: set_ok = bus.set_val < 7'd60;
            3'd2:    set_ok = bus.set_val < 7'd24;
            3'd3:    set_ok = bus.set_val >= 7'd1 &&
                              bus.set_val <= {2'b00, md_cur};
            3'd4:    set_ok = bus.set_val >= 7'd1 && bus.set_val <= 7'd12;
            3'd5:    set_ok = bus.set_val < 7'd100;
            default: set_ok = 1'b0;
        endcase
        sec_wr = bus.set_en & set_ok & (bus.set_sel == 3'd0);
    end

    always_comb begin
        sm     = {1'b0, min_q} + 7'(SNOOZE_MIN);
        s_min  = sm[5:0];
        s_hour = hour_q;
        if (sm >= 7'd60) begin
            s_min  = 6'(sm - 7'd60);
            s_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    always_ff @(posedge CK50M) begin
        if (!RSTn) begin
            presc     <= '0;
            tick_q    <= 1'b0;
            pending   <= 1'b0;
            set_err_q <= 1'b0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            day_q     <= 5'd1;
            month_q   <= 4'd1;
            year_q    <= '0;
        end else begin
            presc     <= (presc == LAST) ? '0 : presc + 1'b1;
            tick_q    <= (presc == LAST);
            set_err_q <= bus.set_en & ~set_ok;
            if (bus.set_en) begin
                // A sec write restarts the second, so any owed tick is void.
                pending <= adv_req & ~sec_wr;
                if (set_ok) begin
                    case (bus.set_sel)
                        3'd0: begin
                            sec_q  <= bus.set_val[5:0];
                            presc  <= '0;
                            tick_q <= 1'b0;
                        end
                        3'd1: min_q  <= bus.set_val[5:0];
                        3'd2: hour_q <= bus.set_val[4:0];
                        3'd3: day_q  <= bus.set_val[4:0];
                        3'd4: begin
                            month_q <= bus.set_val[3:0];
                            if (day_q > md_set) day_q <= md_set;
                        end
                        default: begin
                            year_q <= bus.set_val;
                            if (day_q > md_set) day_q <= md_set;
                        end
                    endcase
                end
            end else if (adv_req) begin
                pending <= 1'b0;
                sec_q   <= n_sec;
                min_q   <= n_min;
                hour_q  <= n_hour;
                day_q   <= n_day;
                month_q <= n_month;
                year_q  <= n_year;
            end
        end
    end

    always_ff @(posedge CK50M) begin
        if (!RSTn) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                ah_q[i] <= '0;
                am_q[i] <= '0;
                ae_q[i] <= 1'b0;
            end
        end else if (bus.al_wr && int'(bus.al_idx) < N_ALARMS) begin
            ah_q[bus.al_idx] <= bus.al_hour;
            am_q[bus.al_idx] <= bus.al_min;
            ae_q[bus.al_idx] <= bus.al_en;
        end
    end

    always_ff @(posedge CK50M) begin
        if (!RSTn) begin
            state  <= IDLE;
            ring_q <= 1'b0;
            ridx_q <= '0;
            cnt    <= '0;
            tgt_h  <= '0;
            tgt_m  <= '0;
        end else begin
            unique case (state)
                IDLE: if (match) begin
                    state  <= RINGING;
                    ring_q <= 1'b1;
                    ridx_q <= hit_idx;
                    cnt    <= 6'(RING_SECS);
                end
                RINGING: begin
                    if (bus.dismiss) begin
                        state  <= IDLE;
                        ring_q <= 1'b0;
                    end else if (bus.snooze) begin
                        state  <= SNOOZED;
                        ring_q <= 1'b0;
                        tgt_h  <= s_hour;
                        tgt_m  <= s_min;
                    end else if (adv) begin
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            state  <= IDLE;
                            ring_q <= 1'b0;
                        end
                    end
                end
                SNOOZED: begin
                    if (bus.dismiss) begin
                        state <= IDLE;
                    end else if (match || snz_hit) begin
                        state  <= RINGING;
                        ring_q <= 1'b1;
                        cnt    <= 6'(RING_SECS);
                        if (match) ridx_q <= hit_idx;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ring_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.day      = day_q;
    assign bus.month    = month_q;
    assign bus.year     = year_q;
    assign bus.sec_tick = tick_q;
    assign bus.ring     = ring_q;
    assign bus.ring_idx = ridx_q;
    assign bus.set_err  = set_err_q;
endmodule

// File: tb/tb_rtc_calendar_alarm.sv
// Directed bench for rtc_calendar_alarm with TICK_DIV=4:
// calendar carries, set checks, collisions, alarm/snooze/dismiss.
module tb_rtc_calendar_alarm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rtc_calendar_alarm_if #(.N_ALARMS(4)) bus ();

    rtc_calendar_alarm #(
        .TICK_DIV  (4),
        .N_ALARMS  (4),
        .RING_SECS (10),
        .SNOOZE_MIN(5)
    ) dut (
        .CK50M(clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick_hi();
        int n = 0;
        while (bus.sec_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("tick_timeout", 32'(n), 0);
    endtask

    task automatic wait_tick();
        wait_tick_hi();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [6:0] val);
        @(negedge clk);
        bus.set_en  = 1'b1;
        bus.set_sel = sel;
        bus.set_val = val;
        @(negedge clk);
        bus.set_en  = 1'b0;
    endtask

    task automatic set_time(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
        wr(3'd0, 7'd0);
        wr(3'd5, 7'(y));
        wr(3'd4, 7'(mo));
        wr(3'd3, 7'(d));
        wr(3'd2, 7'(h));
        wr(3'd1, 7'(mi));
        wr(3'd0, 7'(s));
    endtask

    task automatic al_set(input int idx, input int h, input int m,
                          input logic en);
        @(negedge clk);
        bus.al_wr   = 1'b1;
        bus.al_idx  = 2'(idx);
        bus.al_hour = 5'(h);
        bus.al_min  = 6'(m);
        bus.al_en   = en;
        @(negedge clk);
        bus.al_wr   = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int mi,
                            input int s);
        chk({tag, "_hour"}, 32'(bus.hour), 32'(h));
        chk({tag, "_min"}, 32'(bus.min), 32'(mi));
        chk({tag, "_sec"}, 32'(bus.sec), 32'(s));
    endtask

    task automatic chk_date(input string tag, input int d, input int mo,
                            input int y);
        chk({tag, "_day"}, 32'(bus.day), 32'(d));
        chk({tag, "_month"}, 32'(bus.month), 32'(mo));
        chk({tag, "_year"}, 32'(bus.year), 32'(y));
    endtask

    initial begin
        int ticks, first, seen;
        bus.set_en = 0; bus.set_sel = 0; bus.set_val = 0;
        bus.al_wr = 0; bus.al_idx = 0; bus.al_hour = 0;
        bus.al_min = 0; bus.al_en = 0;
        bus.dismiss = 0; bus.snooze = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk_time("rst", 0, 0, 0);
        chk_date("rst", 1, 1, 0);
        chk("rst_ring", 32'(bus.ring), 0);
        chk("rst_ring_idx", 32'(bus.ring_idx), 0);
        chk("rst_tick", 32'(bus.sec_tick), 0);
        chk("rst_set_err", 32'(bus.set_err), 0);

        ticks = 0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) begin
                ticks++;
                if (first == 0) first = i;
            end
        end
        chk("tick_count", 32'(ticks), 3);
        chk("tick_first", 32'(first), 4);
        chk("tick_sec", 32'(bus.sec), 2);

        set_time(3, 2, 28, 23, 59, 58);
        wait_tick();
        chk_time("t59", 23, 59, 59);
        wait_tick();
        chk_time("rollover03", 0, 0, 0);
        chk_date("rollover03", 1, 3, 3);

        set_time(4, 2, 28, 23, 59, 58);
        wait_tick();
        wait_tick();
        chk_time("leap04", 0, 0, 0);
        chk_date("leap04", 29, 2, 4);

        wr(3'd1, 7'd60);
        chk("min60_err", 32'(bus.set_err), 1);
        chk("min60_keep", 32'(bus.min), 0);
        @(negedge clk);
        chk("err_pulse_end", 32'(bus.set_err), 0);

        set_time(5, 1, 31, 12, 0, 0);
        wr(3'd4, 7'd4);
        chk("clamp_day", 32'(bus.day), 30);
        chk("clamp_month", 32'(bus.month), 4);
        wr(3'd3, 7'd31);
        chk("day31_apr_err", 32'(bus.set_err), 1);
        chk("day31_apr_keep", 32'(bus.day), 30);
        wr(3'd7, 7'd5);
        chk("sel7_err", 32'(bus.set_err), 1);
        chk("sel7_keep", 32'(bus.month), 4);

        set_time(5, 4, 30, 12, 0, 0);
        wait_tick_hi();
        chk("coll_pre_sec", 32'(bus.sec), 0);
        bus.set_en = 1'b1; bus.set_sel = 3'd1; bus.set_val = 7'd10;
        @(negedge clk);
        bus.set_en = 1'b0;
        chk("coll_min", 32'(bus.min), 10);
        chk("coll_sec_held", 32'(bus.sec), 0);
        @(negedge clk);
        chk("coll_sec_late", 32'(bus.sec), 1);

        wait_tick_hi();
        chk("csec_pre", 32'(bus.sec), 1);
        bus.set_en = 1'b1; bus.set_sel = 3'd0; bus.set_val = 7'd30;
        @(negedge clk);
        bus.set_en = 1'b0;
        chk("csec_set", 32'(bus.sec), 30);
        repeat (3) @(negedge clk);
        chk("csec_no_extra", 32'(bus.sec), 30);

        al_set(1, 6, 30, 1'b1);
        al_set(2, 6, 30, 1'b1);
        set_time(5, 4, 30, 6, 29, 59);
        chk("pre_alarm_ring", 32'(bus.ring), 0);
        wait_tick();
        chk_time("alarm", 6, 30, 0);
        chk("alarm_ring", 32'(bus.ring), 1);
        chk("alarm_idx", 32'(bus.ring_idx), 1);
        repeat (9) wait_tick();
        chk("ring_tick9", 32'(bus.ring), 1);
        wait_tick();
        chk("ring_tick10", 32'(bus.ring), 0);
        chk_time("ring_end", 6, 30, 10);

        set_time(5, 4, 30, 6, 29, 59);
        wait_tick();
        chk("snz_ring", 32'(bus.ring), 1);
        repeat (3) wait_tick();
        chk_time("snz_at", 6, 30, 3);
        @(negedge clk);
        bus.snooze = 1'b1;
        @(negedge clk);
        bus.snooze = 1'b0;
        chk("snz_off", 32'(bus.ring), 0);
        for (int i = 0; i < 400; i++) begin
            wait_tick();
            if (bus.ring === 1'b1) break;
        end
        chk("snz_rering", 32'(bus.ring), 1);
        chk_time("snz_rering", 6, 35, 0);
        chk("snz_idx", 32'(bus.ring_idx), 1);

        @(negedge clk);
        bus.dismiss = 1'b1;
        bus.snooze  = 1'b1;
        @(negedge clk);
        bus.dismiss = 1'b0;
        bus.snooze  = 1'b0;
        chk("both_off", 32'(bus.ring), 0);
        seen = 0;
        for (int i = 0; i < 310; i++) begin
            wait_tick();
            if (bus.ring === 1'b1) seen = 1;
        end
        chk("dismiss_wins", 32'(seen), 0);

        set_time(5, 4, 30, 6, 29, 59);
        wait_tick();
        chk("rst_ring_pre", 32'(bus.ring), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ring_drop", 32'(bus.ring), 0);
        chk("rst_mid_day", 32'(bus.day), 1);
        rst_n = 1'b1;
        set_time(0, 1, 1, 6, 29, 59);
        wait_tick();
        chk_time("post_rst", 6, 30, 0);
        chk("post_rst_table", 32'(bus.ring), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rtc_calendar_alarm.md
Name: rtc_calendar_alarm

Overview:
Parametrised real-time clock/calendar core with a multi-entry alarm table, snooze and a set interface with range checks. Runs entirely in the CK50M domain, using a 1 Hz clock-enable rather than a derived clock. It replaces the fixed 1 Hz clock/alarm logic in the board top level. Switch/key decoding and 7-segment drive stay in the top level and connect through the set/alarm ports.

Parameters:
TICK_DIV, 50000000, CK50M cycles per second tick (>=2; benches use 4)
N_ALARMS, 4, number of alarm table entries (1..16)
RING_SECS, 10, seconds the ring output stays high unless dismissed or snoozed (1..63)
SNOOZE_MIN, 5, snooze delay in minutes (1..59)
AW (derived), max(1, clog2(N_ALARMS)), alarm index width

Ports:
CK50M  in  1  system clock
RSTn  in  1  synchronous reset, active low
set_en  in  1  one-cycle strobe: write set_val into field set_sel
set_sel  in  3  0=sec 1=min 2=hour 3=day 4=month 5=year; 6 and 7 are invalid
set_val  in  7  value to write
al_wr  in  1  one-cycle strobe: write alarm entry al_idx
al_idx  in  AW  alarm entry index
al_hour  in  5  alarm hour
al_min  in  6  alarm minute
al_en  in  1  alarm entry enable
dismiss  in  1  stop ringing or cancel a pending snooze
snooze  in  1  stop ringing and re-ring after SNOOZE_MIN minutes
sec  out  6  seconds, 0..59
min  out  6  minutes, 0..59
hour  out  5  hours, 0..23
day  out  5  day of month, 1..31
month  out  4  month, 1..12
year  out  7  year offset from 2000, 0..99
sec_tick  out  1  one-cycle 1 Hz pulse
ring  out  1  alarm sounding
ring_idx  out  AW  entry that caused the current ring or snooze
set_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (RSTn=0 at a CK50M edge): prescaler=0, sec_tick=0, time=00:00:00, date day=1 month=1 year=0, all alarm entries 00:00 disabled, FSM=IDLE, ring=0, ring_idx=0, set_err=0, pending=0.
- Reset mid-ring or mid-snooze drops to IDLE with no further output.
- Prescaler: counts 0..TICK_DIV-1. sec_tick is registered and high for exactly the cycle after count reaches TICK_DIV-1.
- Advance on sec_tick=1: time moves on one second. The update is visible on the next edge.
  - sec 59 carries to min, min 59 carries to hour, hour 23 carries to day.
  - Day carry happens when day == max_day(month, year). It resets day to 1 and carries to month. Month 12 carries to year. Year 99 wraps to 0.
  - max_day: 31 for months 1,3,5,7,8,10,12. 30 for months 4,6,9,11. February is 29 if year%4==0, else 28.
- Set write (set_en=1):
  - Applied on the next edge if valid. Limits: sec/min <60, hour <24, month 1..12, year <100.
  - day must be 1..max_day(current month, current year).
  - Invalid value or set_sel 6/7: no register change, set_err=1 for one cycle.
  - A valid sec write also clears the prescaler.
  - A valid month or year write clamps day to the new max_day if the current day exceeds it.
- Set/tick collision (set_en and sec_tick in the same cycle): the set is applied, pending is set, and the one-second advance is performed on the following cycle (no lost second). If the set was a sec write, the deferred tick is discarded.
- Alarm write (al_wr=1): entry al_idx takes {al_hour, al_min, al_en} on the next edge. There is no range check, so an out-of-range hour or min simply never matches. al_idx >= N_ALARMS is ignored.
- Match: evaluated on the advance cycle against the post-advance time. A match needs new sec==0 and an enabled entry whose hour and min equal the new time. If several entries match, the lowest index wins. ring rises on the same edge the time shows hh:mm:00.
- Ring FSM states: IDLE, RINGING, SNOOZED.
  - IDLE, on a table match: go to RINGING, ring=1, ring_idx=match, ring counter=RING_SECS.
  - RINGING:
    - Each advance decrements the counter; reaching 0 gives IDLE with ring=0.
    - dismiss gives IDLE.
    - snooze gives SNOOZED with target = current hh:mm + SNOOZE_MIN, mod 24 h.
    - dismiss and snooze together: dismiss wins.
    - New matches are ignored.
  - SNOOZED:
    - An advance where the new time is target:00 gives RINGING, keeping ring_idx and reloading the counter.
    - A table match also gives RINGING with the new ring_idx; the snooze is dropped.
    - dismiss gives IDLE.
- Time counting never stalls during set, alarm write or ringing.

Test Plan:
- TICK_DIV=4; release reset -> sec_tick every 4th cycle; outputs 00:00:00, date 1/1/00; ring=0.
- Set 23:59:58 on 28/2/03, run 2 ticks -> 00:00:00 on 1/3/03; repeat with year=04 -> 29/2/04.
- set_sel=1 with set_val=60 -> set_err pulse, min unchanged. On 31/1, set month=4 -> day clamps to 30. set_sel=7 -> set_err.
- Issue set_en min=10 in the same cycle as sec_tick -> min=10 and sec advances one cycle later. Repeat with a sec write -> no extra advance.
- Enable alarms 1 and 2 both at 06:30; start from 06:29:59 -> ring=1, ring_idx=1 at 06:30:00; ring=0 after 10 ticks.
- Ring at 06:30; pulse snooze at 06:30:03 -> ring=0; ring=1 at 06:35:00 with ring_idx kept. dismiss+snooze together -> IDLE. Assert RSTn=0 while ringing -> ring=0 on the next edge.
